// File: rtl/fir_decim_pkg.sv
// Shared constants, FSM state type and the production coefficient set for the
// compensating FIR decimator.
package fir_decim_pkg;

    localparam int TAPS_DEF       = 32;
    localparam int COEF_WIDTH_DEF = 18;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        MAC   = 2'd2,
        ROUND = 2'd3
    } state_t;

    // Symmetric 32-tap set; the coefficients sum to 2^17, so DC gain is unity after OUT_SHIFT=17.
    localparam logic signed [COEF_WIDTH_DEF-1:0] FIR_COEFS [TAPS_DEF] = '{
        -18'sd120,   -18'sd310,   -18'sd280,    18'sd260,
         18'sd900,    18'sd610,   -18'sd980,   -18'sd2400,
        -18'sd1150,   18'sd3100,   18'sd6200,   18'sd2300,
        -18'sd7800,  -18'sd15400, -18'sd2100,   18'sd82706,
         18'sd82706, -18'sd2100,  -18'sd15400, -18'sd7800,
         18'sd2300,   18'sd6200,   18'sd3100,  -18'sd1150,
        -18'sd2400,  -18'sd980,    18'sd610,    18'sd900,
         18'sd260,   -18'sd280,   -18'sd310,   -18'sd120
    };

endpackage

// File: rtl/fir_coef_rom.sv
// Registered-output coefficient ROM; one cycle from addr to coef.
module fir_coef_rom
    import fir_decim_pkg::*;
#(
    parameter int TAPS       = TAPS_DEF,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter logic signed [COEF_WIDTH-1:0] COEFS [TAPS] = FIR_COEFS
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [$clog2(TAPS)-1:0]      addr,
    output logic signed [COEF_WIDTH-1:0] coef
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coef <= '0;
        end else begin
            coef <= COEFS[addr];
        end
    end

endmodule

// File: rtl/fir_decim.sv
// Compensating FIR decimator: ring-buffers CIC samples and produces one
// serial-MAC, rounded and saturated output every DECIM accepted samples.
module fir_decim
    import fir_decim_pkg::*;
#(
    parameter int IN_WIDTH   = 20,
    parameter int COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int TAPS       = TAPS_DEF,
    parameter int DECIM      = 2,
    parameter int OUT_WIDTH  = 24,
    parameter int OUT_SHIFT  = 17,
    parameter int ACC_WIDTH  = IN_WIDTH + COEF_WIDTH + $clog2(TAPS),
    parameter logic signed [COEF_WIDTH-1:0] COEFS [TAPS] = FIR_COEFS
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        in_ready,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        overrun
);

    localparam int AW     = $clog2(TAPS);
    localparam int PROD_W = IN_WIDTH + COEF_WIDTH;

    // Handshake: a sample transfers on any clock edge where in_strobe && in_ready;
    // in_strobe with in_ready low is dropped and flagged on overrun the next cycle.
    state_t                      state, state_nxt;
    logic [AW-1:0]               wptr;
    logic [AW-1:0]               phase;
    logic [AW:0]                 step;
    logic signed [IN_WIDTH-1:0]  ram [TAPS];
    logic signed [IN_WIDTH-1:0]  ram_q;
    logic signed [COEF_WIDTH-1:0] rom_q;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH:0]   rounded;
    logic signed [OUT_WIDTH-1:0] sat;
    logic [AW-1:0]               rd_addr;
    logic                        accept, last_phase, ram_we;

    assign last_phase = (phase == AW'(DECIM - 1));
    assign ram_we     = (state == CLEAR) || accept;
    assign rd_addr    = wptr - AW'(1) - step[AW-1:0];

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            CLEAR: if (wptr == AW'(TAPS - 1)) state_nxt = IDLE;
            IDLE: begin
                accept = in_strobe;
                if (in_strobe && last_phase) state_nxt = MAC;
            end
            MAC:   if (step == (AW + 1)'(TAPS + 1)) state_nxt = ROUND;
            ROUND: state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    // Round half up, then clamp anything that does not fit OUT_WIDTH.
    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        rounded = (ACC_WIDTH + 1)'(shifted) + (ACC_WIDTH + 1)'(acc[OUT_SHIFT-1]);
        if ((&rounded[ACC_WIDTH:OUT_WIDTH-1]) || (~|rounded[ACC_WIDTH:OUT_WIDTH-1])) begin
            sat = rounded[OUT_WIDTH-1:0];
        end else if (rounded[ACC_WIDTH]) begin
            sat = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end else begin
            sat = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end
    end

    // Sample RAM: no reset, CLEAR zero-fills it through the write pointer.
    always_ff @(posedge clock) begin
        if (ram_we) ram[wptr] <= (state == CLEAR) ? '0 : in_data;
        ram_q <= ram[rd_addr];
    end

    fir_coef_rom #(
        .TAPS       (TAPS),
        .COEF_WIDTH (COEF_WIDTH),
        .COEFS      (COEFS)
    ) u_rom (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (step[AW-1:0]),
        .coef    (rom_q)
    );

    // MAC pipeline: step k issues reads, step k+1 registers the product,
    // step k+2 accumulates it; MAC therefore spans TAPS+2 cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            wptr       <= '0;
            phase      <= '0;
            step       <= '0;
            prod       <= '0;
            acc        <= '0;
            in_ready   <= 1'b0;
            out_strobe <= 1'b0;
            out_data   <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_strobe <= 1'b0;
            overrun    <= in_strobe && !in_ready;
            if (ram_we) wptr <= wptr + AW'(1);
            if (state == CLEAR && state_nxt == IDLE) in_ready <= 1'b1;
            if (accept) begin
                phase <= last_phase ? '0 : phase + AW'(1);
                if (last_phase) begin
                    in_ready <= 1'b0;
                    step     <= '0;
                    acc      <= '0;
                end
            end
            if (state == MAC) begin
                step <= step + (AW + 1)'(1);
                prod <= PROD_W'(ram_q) * PROD_W'(rom_q);
                if (step >= (AW + 1)'(2)) acc <= acc + ACC_WIDTH'(prod);
            end
            if (state == ROUND) begin
                out_data   <= sat;
                out_strobe <= 1'b1;
                in_ready   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_decim.sv
// Bench for fir_decim: cycle-stepped driver, sample-history reference model and
// expected-output queues for a production DUT and a flat full-scale-coefficient DUT.
module tb_fir_decim;
    import fir_decim_pkg::*;

    localparam int IN_W  = 20;
    localparam int OUT_W = 24;
    localparam int DECIM = 2;
    localparam int TAPS  = 32;
    localparam longint OUT_MAX = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint OUT_MIN = -(64'sd1 <<< (OUT_W - 1));
    localparam logic signed [17:0] SAT_COEFS [32] = '{default: 18'sd131071};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    logic in_strobe;
    logic signed [IN_W-1:0] in_data;
    logic in_ready, out_strobe, overrun;
    logic signed [OUT_W-1:0] out_data;
    logic in_ready_s, out_strobe_s, overrun_s;
    logic signed [OUT_W-1:0] out_data_s;

    always #5 clock = ~clock;

    fir_decim dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_strobe  (in_strobe),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_strobe (out_strobe),
        .out_data   (out_data),
        .overrun    (overrun)
    );

    fir_decim #(.COEFS(SAT_COEFS)) dut_sat (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_strobe  (in_strobe),
        .in_data    (in_data),
        .in_ready   (in_ready_s),
        .out_strobe (out_strobe_s),
        .out_data   (out_data_s),
        .overrun    (overrun_s)
    );

    // ---------------- scoreboard / model state ----------------
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_sat_q[$];
    int hist[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int m_phase, clear_cnt, busy_cnt;
    bit m_ready;
    logic signed [OUT_W-1:0] m_out, m_out_s, last_out, last_sat;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Filter output from the last TAPS accepted samples, newest against tap 0.
    function automatic logic signed [OUT_W-1:0] model_out(input bit flat);
        longint acc = 0;
        longint r;
        for (int k = 0; k < TAPS; k++) begin
            acc += longint'(hist[hist.size() - 1 - k]) *
                   (flat ? longint'(SAT_COEFS[k]) : longint'(FIR_COEFS[k]));
        end
        r = (acc >>> 17) + ((acc >>> 16) & 64'sd1);
        if (r > OUT_MAX) r = OUT_MAX;
        if (r < OUT_MIN) r = OUT_MIN;
        return r[OUT_W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit strb, input int d);
        bit ovr_exp, acc_now, stb_exp;
        in_strobe = strb;
        in_data   = strb ? d[IN_W-1:0] : '0;
        @(posedge clock);
        ovr_exp = strb && !m_ready;
        acc_now = strb && m_ready;
        stb_exp = 1'b0;
        if (clear_cnt > 0) begin
            clear_cnt--;
            if (clear_cnt == 0) m_ready = 1'b1;
        end
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                stb_exp = 1'b1;
                m_ready = 1'b1;
                m_out   = exp_q.pop_front();
                m_out_s = exp_sat_q.pop_front();
            end
        end
        if (acc_now) begin
            hist.push_back(d);
            if (hist.size() > TAPS) void'(hist.pop_front());
            m_phase++;
            if (m_phase == DECIM) begin
                m_phase  = 0;
                m_ready  = 1'b0;
                busy_cnt = TAPS + 3;
                exp_q.push_back(model_out(1'b0));
                exp_sat_q.push_back(model_out(1'b1));
            end
        end
        #1;
        chk("in_ready", in_ready, m_ready);
        chk("overrun", overrun, ovr_exp);
        chk("out_strobe", out_strobe, stb_exp);
        chk("out_data", out_data, m_out);
        chk("sat_in_ready", in_ready_s, m_ready);
        chk("sat_overrun", overrun_s, ovr_exp);
        chk("sat_out_strobe", out_strobe_s, stb_exp);
        chk("sat_out_data", out_data_s, m_out_s);
        if (out_strobe) begin
            last_out = out_data;
            n_out++;
        end
        if (out_strobe_s) last_sat = out_data_s;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0);
    endtask

    task automatic send(input int d, input int gap);
        cycle(1'b1, d);
        idle(gap - 1);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clock);
        reset_n   = 1'b0;
        in_strobe = 1'b0;
        in_data   = '0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_strobe", out_strobe, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sat_out_data", out_data_s, 0);
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        hist.delete();
        for (int i = 0; i < TAPS; i++) hist.push_back(0);
        exp_q.delete();
        exp_sat_q.delete();
        m_phase   = 0;
        m_ready   = 1'b0;
        clear_cnt = TAPS;
        busy_cnt  = 0;
        m_out     = '0;
        m_out_s   = '0;
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        longint sumc = 0;
        longint exp_dc;
        reset_n   = 1'b0;
        in_strobe = 1'b0;
        in_data   = '0;
        last_out  = '0;
        last_sat  = '0;

        // Reset, then a strobe landing inside CLEAR.
        apply_reset(3);
        idle(10);
        cycle(1'b1, 1234);
        idle(30);

        // Impulse of 2^17 followed by zeros.
        n_out = 0;
        send(1 << 17, 40);
        repeat (31) send(0, 40);
        idle(5);
        chk("impulse_count", n_out, 16);

        // DC gain.
        for (int k = 0; k < TAPS; k++) sumc += longint'(FIR_COEFS[k]);
        exp_dc = (1000 * sumc + 65536) >>> 17;
        repeat (64) send(1000, 40);
        chk("dc_settled", last_out, 32'(exp_dc));

        // Full-scale inputs into the flat coefficient set.
        repeat (36) send((1 << (IN_W - 1)) - 1, TAPS + 4);
        chk("sat_pos", last_sat, 32'sd8388607);
        repeat (36) send(-(1 << (IN_W - 1)), TAPS + 4);
        chk("sat_neg", last_sat, -32'sd8388608);

        // Strobes faster than the filter can take them.
        repeat (40) send(rand_sample(), 10);
        idle(40);

        // Random data and spacing, some spacings inside the busy window.
        repeat (80) send(rand_sample(), int'($urandom_range(1, 45)));
        idle(40);

        // Reset five clocks into a MAC, then re-run the impulse.
        for (int i = 0; i < DECIM && busy_cnt == 0; i++) cycle(1'b1, 777);
        idle(5);
        apply_reset(2);
        idle(40);
        n_out = 0;
        send(1 << 17, 40);
        repeat (31) send(0, 40);
        idle(5);
        chk("impulse2_count", n_out, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
